// File: rtl/bundler_core.sv
// bundler_core: walks slice index d across the hypervector, majority-votes each
// PAR_BITS-wide slice from upstream and assembles the bundled hv_out.
module bundler_core #(
  parameter int DIMENSIONS = 10000,
  parameter int NUM_HVS    = 17,
  parameter int PAR_BITS   = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic [1:0]                        state,
  output logic [$clog2(DIMENSIONS)-1:0]     d,
  input  logic                              bundler_bits_en,
  input  logic [NUM_HVS-1:0][PAR_BITS-1:0]  bundler_bits_in,
  input  logic [PAR_BITS-1:0]               ties_1,
  input  logic [PAR_BITS-1:0]               ties_2,
  output logic [DIMENSIONS-1:0]             hv_out,
  output logic                              done
);

  // state | meaning
  // IDLE  | waiting for start, d parked at 0
  // RUN   | one slice per cycle, d advances by PAR_BITS
  // FLUSH | last captured slice lands in hv_out
  // DONE  | done pulse, hv_out complete
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int DW = $clog2(DIMENSIONS);
  localparam int CW = $clog2(NUM_HVS + 2);
  localparam logic [DW-1:0] LAST_D = DW'(DIMENSIONS - PAR_BITS);
  localparam logic [DW-1:0] STEP   = DW'(PAR_BITS);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DW-1:0]         r_d;
  logic [DW-1:0]         w_d_nxt;
  logic                  w_capture;
  logic                  w_clear;
  logic                  r_pv;
  logic [PAR_BITS-1:0]   r_pword;
  logic [DW-1:0]         r_pd;
  logic [DIMENSIONS-1:0] r_hv;
  logic [PAR_BITS-1:0]   w_maj;

  always_comb begin
    w_state_nxt = r_state;
    w_d_nxt     = r_d;
    w_capture   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_d_nxt = '0;
        if (start) begin
          w_state_nxt = S_RUN;
          w_clear     = 1'b1;
        end
      end
      S_RUN: begin
        w_capture = bundler_bits_en;
        if (r_d == LAST_D) begin
          w_d_nxt     = '0;
          w_state_nxt = S_FLUSH;
        end else begin
          w_d_nxt = r_d + STEP;
        end
      end
      S_FLUSH: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_d     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_d     <= w_d_nxt;
    end
  end

  // One-stage pipeline: majority word and its slice base, written back next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv    <= 1'b0;
      r_pword <= '0;
      r_pd    <= '0;
    end else begin
      r_pv <= w_capture;
      if (w_capture) begin
        r_pword <= w_maj;
        r_pd    <= r_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hv <= '0;
    end else if (w_clear) begin
      r_hv <= '0;
    end else if (r_pv) begin
      r_hv[r_pd +: PAR_BITS] <= r_pword;
    end
  end

  for (genvar b = 0; b < PAR_BITS; b++) begin : g_bit
    logic [CW-1:0] w_cnt;

    always_comb begin
      w_cnt = '0;
      for (int i = 0; i < NUM_HVS; i++) begin
        w_cnt = w_cnt + CW'(bundler_bits_in[i][b]);
      end
    end

    if (NUM_HVS % 2 == 0) begin : g_tie
      // The tie vote only matters on an exact split; otherwise it cannot reach threshold.
      logic [CW-1:0] w_cnt_t;
      assign w_cnt_t  = w_cnt + CW'(ties_1[b] ^ ties_2[b]);
      assign w_maj[b] = (w_cnt_t >= CW'(NUM_HVS / 2 + 1));
    end else begin : g_odd
      assign w_maj[b] = (w_cnt >= CW'((NUM_HVS + 1) / 2));
    end
  end

  if (NUM_HVS % 2 != 0) begin : g_no_ties
    logic w_unused_ties;
    assign w_unused_ties = ^{ties_1, ties_2};
  end

  assign state  = r_state;
  assign d      = r_d;
  assign hv_out = r_hv;
  assign done   = (r_state == S_DONE);

endmodule

// File: doc/bundler_core.md
Name: bundler_core

Overview:
- Sequencing and majority-vote stage of the HDC bundler. It pairs with the combinational slice extractor directly upstream.
- It drives the 2-bit `state` and dimension index `d` consumed by that extractor, and receives the extracted PAR_BITS-wide slices plus tie-break words.
- It computes a per-bit majority and assembles the full DIMENSIONS-bit bundled hypervector, one slice per cycle.
- Downstream logic (similarity/AM search) takes `hv_out` when `done` pulses.

Parameters:
- DIMENSIONS, 10000: hypervector length. Must be a multiple of PAR_BITS.
- NUM_HVS, 17: number of hypervectors bundled.
- PAR_BITS, 10: bits processed per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a bundling pass; sampled only in IDLE.
- state  out  2  FSM state: 0 IDLE, 1 RUN, 2 FLUSH, 3 DONE.
- d  out  $clog2(DIMENSIONS)  current slice base index.
- bundler_bits_en  in  1  slice-valid from upstream; high only while state==1.
- bundler_bits_in  in  NUM_HVS×PAR_BITS  slice bits; [i][b] is bit d+b of HV i.
- ties_1  in  PAR_BITS  tie-break word A. Used only when NUM_HVS is even.
- ties_2  in  PAR_BITS  tie-break word B. Used only when NUM_HVS is even.
- hv_out  out  DIMENSIONS  bundled hypervector.
- done  out  1  one-cycle pulse when hv_out is complete.

Behaviour:
- Reset values: state=0, d=0, hv_out=0, done=0, and the pipeline register valid=0. Reset mid-pass aborts immediately; no partial write occurs in the reset cycle.
- State IDLE (0):
  - d held at 0.
  - start=1 → RUN next cycle.
- State RUN (1):
  - Each cycle with bundler_bits_en=1, compute the majority word for slice d and register it, together with d, into a one-stage pipeline.
  - d increments by PAR_BITS each cycle.
  - When d == DIMENSIONS−PAR_BITS, d returns to 0 and the FSM moves to FLUSH.
  - RUN lasts exactly DIMENSIONS/PAR_BITS cycles.
- Pipeline write: the cycle after capture, hv_out[wd +: PAR_BITS] is written with the registered word, where wd is the registered index. hv_out bits are never written outside this path, apart from the hv_out clear on start (below).
- State FLUSH (1 cycle): the last registered slice is written; FSM → DONE.
- State DONE (1 cycle): done=1; FSM → IDLE. done is 0 in all other states.
- Start handling:
  - start is ignored outside IDLE.
  - start in the DONE cycle is ignored; it must be reasserted in IDLE.
- Pass boundaries: hv_out holds its value from DONE until the next start. On start in IDLE, hv_out is cleared to 0 in the same edge.
- Majority, NUM_HVS odd: for each bit b, cnt = popcount over i of bundler_bits_in[i][b]; out[b] = (cnt ≥ (NUM_HVS+1)/2).
- Majority, NUM_HVS even: an extra vote t[b] = ties_1[b] XOR ties_2[b] is added; cnt' = cnt + t[b]; out[b] = (cnt' ≥ NUM_HVS/2+1).
  - Consequence: with an exact split, t decides; otherwise t never overrides.
- Counter width: cnt width is $clog2(NUM_HVS+2) bits, with no overflow possible.
- Slice-valid low: if bundler_bits_en=0 during RUN (upstream fault), no capture occurs for that slice and d still advances.
- Latency: start edge → done high = DIMENSIONS/PAR_BITS + 2 cycles. With defaults, 1000 + 2 = 1002.
- Generate: the ties logic is elaborated only when NUM_HVS%2==0. For odd NUM_HVS, ties_1 and ties_2 are unused.

Test Plan:
1. Reset/idle (DIMENSIONS=20, PAR_BITS=10, NUM_HVS=3): assert rst 3 cycles → state=0, d=0, hv_out=0, done=0; start=0 for 10 cycles → nothing changes.
2. Odd majority (same params): HVs 0x00000, 0xFFFFF, 0x0F0F0 with a behavioural slicer; pulse start → d=0 then 10; done exactly 4 cycles after start edge; hv_out=0x0F0F0.
3. Even tie-break (NUM_HVS=4): HV0=HV1=all-1s, HV2=HV3=0; ties_1=0x3FF, ties_2=0x000 → hv_out all-1s. Then ties_2=0x3FF → hv_out all-0s. Unanimous cases are unaffected by ties.
4. Back-to-back passes: start held high continuously → second pass begins in the IDLE cycle after DONE; hv_out cleared at second start; done pulses 5 cycles apart.
5. Reset mid-RUN: assert rst when d=10 → next cycle state=0, d=0, hv_out=0, no done pulse; a subsequent start completes normally.
6. Start ignored: pulse start during RUN and during DONE → no restart, d sequence unchanged, a single done pulse.
